// File: rtl/ram_bus_arbiter_if.sv
// Bus bundle for the RAM arbiter: three requester ports on one side, the shared RAM on the other.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface ram_bus_arbiter_if;
  logic        dbg_req_i;
  logic [31:0] dbg_addr_i;
  logic        dbg_we_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_gnt_o;
  logic        dbg_rvalid_o;
  logic [31:0] dbg_rdata_o;

  logic        dmem_req_i;
  logic [31:0] dmem_addr_i;
  logic        dmem_we_i;
  logic [2:0]  dmem_size_i;
  logic [31:0] dmem_wdata_i;
  logic        dmem_gnt_o;
  logic        dmem_rvalid_o;
  logic [31:0] dmem_rdata_o;

  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;

  logic [31:0] ram_addr_o;
  logic        ram_we_o;
  logic        ram_re_o;
  logic [2:0]  ram_size_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;

  logic        hold_flag_o;

  modport slave (
    input  dbg_req_i, dbg_addr_i, dbg_we_i, dbg_wdata_i,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    input  dmem_req_i, dmem_addr_i, dmem_we_i, dmem_size_i, dmem_wdata_i,
    output dmem_gnt_o, dmem_rvalid_o, dmem_rdata_o,
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output ram_addr_o, ram_we_o, ram_re_o, ram_size_o, ram_wdata_o,
    input  ram_rdata_i,
    output hold_flag_o
  );

  modport master (
    output dbg_req_i, dbg_addr_i, dbg_we_i, dbg_wdata_i,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    output dmem_req_i, dmem_addr_i, dmem_we_i, dmem_size_i, dmem_wdata_i,
    input  dmem_gnt_o, dmem_rvalid_o, dmem_rdata_o,
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ram_addr_o, ram_we_o, ram_re_o, ram_size_o, ram_wdata_o,
    output ram_rdata_i,
    input  hold_flag_o
  );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Fixed-priority arbiter sharing one single-port RAM between debug, data and fetch ports,
// with a fetch starvation guard and read-response routing after RAM_LAT cycles.
module ram_bus_arbiter #(
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_bus_arbiter_if.slave bus
);

  localparam logic [1:0] OWN_DMEM   = 2'd0;
  localparam logic [1:0] OWN_IF     = 2'd1;
  localparam logic [1:0] OWN_DBG    = 2'd2;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]         starve_cnt;
  logic               if_prio;
  logic               gnt_dbg;
  logic               gnt_dmem;
  logic               gnt_if;
  logic [1:0]         rd_owner;
  logic [RAM_LAT-1:0] pipe_valid;
  logic [1:0]         pipe_owner [RAM_LAT];
  logic               tail_valid;
  logic [1:0]         tail_owner;

  assign if_prio = (starve_cnt == STARVE_LIM);

  // Grants are masked by rst_n so nothing reaches the RAM while reset is held.
  always_comb begin
    gnt_dbg  = 1'b0;
    gnt_dmem = 1'b0;
    gnt_if   = 1'b0;
    if (rst_n) begin
      if (if_prio && bus.if_req_i)  gnt_if   = 1'b1;
      else if (bus.dbg_req_i)       gnt_dbg  = 1'b1;
      else if (bus.dmem_req_i)      gnt_dmem = 1'b1;
      else if (bus.if_req_i)        gnt_if   = 1'b1;
    end
  end

  always_comb begin
    bus.ram_addr_o  = 32'h0;
    bus.ram_we_o    = 1'b0;
    bus.ram_re_o    = 1'b0;
    bus.ram_size_o  = 3'b000;
    bus.ram_wdata_o = 32'h0;
    rd_owner        = OWN_DMEM;
    if (gnt_dbg) begin
      bus.ram_addr_o  = bus.dbg_addr_i;
      bus.ram_we_o    = bus.dbg_we_i;
      bus.ram_re_o    = ~bus.dbg_we_i;
      bus.ram_size_o  = SIZE_WORD;
      bus.ram_wdata_o = bus.dbg_wdata_i;
      rd_owner        = OWN_DBG;
    end else if (gnt_dmem) begin
      bus.ram_addr_o  = bus.dmem_addr_i;
      bus.ram_we_o    = bus.dmem_we_i;
      bus.ram_re_o    = ~bus.dmem_we_i;
      bus.ram_size_o  = bus.dmem_size_i;
      bus.ram_wdata_o = bus.dmem_wdata_i;
      rd_owner        = OWN_DMEM;
    end else if (gnt_if) begin
      bus.ram_addr_o  = bus.if_addr_i;
      bus.ram_re_o    = 1'b1;
      bus.ram_size_o  = SIZE_WORD;
      rd_owner        = OWN_IF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (!bus.if_req_i || gnt_if) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // One slot per cycle of RAM latency; writes enter as invalid so they never produce rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      for (int i = 0; i < RAM_LAT; i++) pipe_owner[i] <= OWN_DMEM;
    end else begin
      pipe_valid[0] <= bus.ram_re_o;
      pipe_owner[0] <= rd_owner;
      for (int i = 1; i < RAM_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_owner[i] <= pipe_owner[i-1];
      end
    end
  end

  assign tail_valid = pipe_valid[RAM_LAT-1];
  assign tail_owner = pipe_owner[RAM_LAT-1];

  assign bus.dbg_gnt_o     = gnt_dbg;
  assign bus.dmem_gnt_o    = gnt_dmem;
  assign bus.if_gnt_o      = gnt_if;
  assign bus.hold_flag_o   = rst_n & bus.if_req_i & ~gnt_if;

  assign bus.dbg_rvalid_o  = tail_valid && (tail_owner == OWN_DBG);
  assign bus.dmem_rvalid_o = tail_valid && (tail_owner == OWN_DMEM);
  assign bus.if_rvalid_o   = tail_valid && (tail_owner == OWN_IF);

  assign bus.dbg_rdata_o   = bus.dbg_rvalid_o  ? bus.ram_rdata_i : 32'h0;
  assign bus.dmem_rdata_o  = bus.dmem_rvalid_o ? bus.ram_rdata_i : 32'h0;
  assign bus.if_rdata_o    = bus.if_rvalid_o   ? bus.ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter (RAM_LAT = 2, STARVE_MAX = 4) with a small delayed-read RAM model.
module tb_ram_bus_arbiter;
  localparam int LAT = 2;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ram_bus_arbiter_if bus ();

  ram_bus_arbiter #(.RAM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : {a[15:0], 16'hC0DE};
  endfunction

  // RAM model: read data appears exactly LAT (=2) cycles after ram_re_o; garbage otherwise.
  logic        d0_v = 1'b0, d1_v = 1'b0;
  logic [31:0] d0_a = 32'h0, d1_a = 32'h0;
  always @(posedge clk) begin
    d0_v <= bus.ram_re_o;
    d0_a <= bus.ram_addr_o;
    d1_v <= d0_v;
    d1_a <= d0_a;
  end
  assign bus.ram_rdata_i = d1_v ? rd_fn(d1_a) : 32'hBAD0_BAD0;

  typedef struct {
    string       name;
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [2:0]  dmem_size;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        if_req;
    logic [31:0] if_addr;
    logic [2:0]  exp_gnt;   // {dbg, dmem, if}
    logic        exp_hold;
    logic        exp_re;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [2:0]  exp_size;
    logic [31:0] exp_wdata;
    logic [2:0]  exp_rv;    // {dbg, dmem, if}
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [27];

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] all_outputs();
    return {bus.dbg_gnt_o, bus.dmem_gnt_o, bus.if_gnt_o, bus.hold_flag_o,
            bus.ram_re_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_size_o, bus.ram_wdata_o,
            bus.dbg_rvalid_o, bus.dmem_rvalid_o, bus.if_rvalid_o,
            bus.dbg_rdata_o, bus.dmem_rdata_o, bus.if_rdata_o};
  endfunction

  task automatic drive(input logic dq, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                       input logic mq, input logic mwe, input logic [2:0] msz, input logic [31:0] ma,
                       input logic [31:0] mwd, input logic iq, input logic [31:0] ia);
    bus.dbg_req_i    = dq;
    bus.dbg_we_i     = dwe;
    bus.dbg_addr_i   = da;
    bus.dbg_wdata_i  = dwd;
    bus.dmem_req_i   = mq;
    bus.dmem_we_i    = mwe;
    bus.dmem_size_i  = msz;
    bus.dmem_addr_i  = ma;
    bus.dmem_wdata_i = mwd;
    bus.if_req_i     = iq;
    bus.if_addr_i    = ia;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] e_dbg, e_dm, e_if;
    drive(v.dbg_req, v.dbg_we, v.dbg_addr, v.dbg_wdata, v.dmem_req, v.dmem_we, v.dmem_size,
          v.dmem_addr, v.dmem_wdata, v.if_req, v.if_addr);
    #4;
    e_dbg = v.exp_rv[2] ? v.exp_rdata : 32'h0;
    e_dm  = v.exp_rv[1] ? v.exp_rdata : 32'h0;
    e_if  = v.exp_rv[0] ? v.exp_rdata : 32'h0;
    check({v.name, " gnt"}, 256'({bus.dbg_gnt_o, bus.dmem_gnt_o, bus.if_gnt_o}), 256'(v.exp_gnt));
    check({v.name, " hold"}, 256'(bus.hold_flag_o), 256'(v.exp_hold));
    check({v.name, " ram_bus"},
          256'({bus.ram_re_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_size_o, bus.ram_wdata_o}),
          256'({v.exp_re, v.exp_we, v.exp_addr, v.exp_size, v.exp_wdata}));
    check({v.name, " resp"},
          256'({bus.dbg_rvalid_o, bus.dmem_rvalid_o, bus.if_rvalid_o,
                bus.dbg_rdata_o, bus.dmem_rdata_o, bus.if_rdata_o}),
          256'({v.exp_rv, e_dbg, e_dm, e_if}));
  endtask

  initial begin
    //          name        dbg: req we addr      wdata          dmem: req we size    addr          wdata          if: req addr         gnt    hold  re    we    addr          size    wdata          rv     rdata
    vecs[0]  = '{"t1_if",    1'b0,1'b0,32'h0,    32'h0,         1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b1,32'h100,    3'b001,1'b0,1'b1,1'b0,32'h100,    3'b010,32'h0,         3'b000,32'h0};
    vecs[1]  = '{"t1_wait",  1'b0,1'b0,32'h0,    32'h0,         1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b0,32'h0,      3'b000,1'b0,1'b0,1'b0,32'h0,      3'b000,32'h0,         3'b000,32'h0};
    vecs[2]  = '{"t1_resp",  1'b0,1'b0,32'h0,    32'h0,         1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b0,32'h0,      3'b000,1'b0,1'b0,1'b0,32'h0,      3'b000,32'h0,         3'b001,32'h0000_0013};
    vecs[3]  = '{"t2_both",  1'b0,1'b0,32'h0,    32'h0,         1'b1,1'b0,3'b010,32'h2000,     32'h0,         1'b1,32'h104,    3'b010,1'b1,1'b1,1'b0,32'h2000,   3'b010,32'h0,         3'b000,32'h0};
    vecs[4]  = '{"t2_if",    1'b0,1'b0,32'h0,    32'h0,         1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b1,32'h104,    3'b001,1'b0,1'b1,1'b0,32'h104,    3'b010,32'h0,         3'b000,32'h0};
    vecs[5]  = '{"t2_rdm",   1'b0,1'b0,32'h0,    32'h0,         1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b0,32'h0,      3'b000,1'b0,1'b0,1'b0,32'h0,      3'b000,32'h0,         3'b010,32'h2000_C0DE};
    vecs[6]  = '{"t2_rif",   1'b0,1'b0,32'h0,    32'h0,         1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b0,32'h0,      3'b000,1'b0,1'b0,1'b0,32'h0,      3'b000,32'h0,         3'b001,32'h0104_C0DE};
    vecs[7]  = '{"t3_st",    1'b0,1'b0,32'h0,    32'h0,         1'b1,1'b1,3'b000,32'h3000,     32'hDEADBEEF,  1'b0,32'h0,      3'b010,1'b0,1'b0,1'b1,32'h3000,   3'b000,32'hDEADBEEF,  3'b000,32'h0};
    vecs[8]  = '{"t3_idle",  1'b0,1'b0,32'h0,    32'h0,         1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b0,32'h0,      3'b000,1'b0,1'b0,1'b0,32'h0,      3'b000,32'h0,         3'b000,32'h0};
    vecs[9]  = '{"t3_norv",  1'b0,1'b0,32'h0,    32'h0,         1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b0,32'h0,      3'b000,1'b0,1'b0,1'b0,32'h0,      3'b000,32'h0,         3'b000,32'h0};
    vecs[10] = '{"t4_c1",    1'b0,1'b0,32'h0,    32'h0,         1'b1,1'b0,3'b010,32'h4000,     32'h0,         1'b1,32'h200,    3'b010,1'b1,1'b1,1'b0,32'h4000,   3'b010,32'h0,         3'b000,32'h0};
    vecs[11] = '{"t4_c2",    1'b0,1'b0,32'h0,    32'h0,         1'b1,1'b0,3'b010,32'h4004,     32'h0,         1'b1,32'h200,    3'b010,1'b1,1'b1,1'b0,32'h4004,   3'b010,32'h0,         3'b000,32'h0};
    vecs[12] = '{"t4_c3",    1'b0,1'b0,32'h0,    32'h0,         1'b1,1'b0,3'b010,32'h4008,     32'h0,         1'b1,32'h200,    3'b010,1'b1,1'b1,1'b0,32'h4008,   3'b010,32'h0,         3'b010,32'h4000_C0DE};
    vecs[13] = '{"t4_c4",    1'b0,1'b0,32'h0,    32'h0,         1'b1,1'b0,3'b010,32'h400C,     32'h0,         1'b1,32'h200,    3'b010,1'b1,1'b1,1'b0,32'h400C,   3'b010,32'h0,         3'b010,32'h4004_C0DE};
    vecs[14] = '{"t4_c5",    1'b0,1'b0,32'h0,    32'h0,         1'b1,1'b0,3'b010,32'h4010,     32'h0,         1'b1,32'h200,    3'b001,1'b0,1'b1,1'b0,32'h200,    3'b010,32'h0,         3'b010,32'h4008_C0DE};
    vecs[15] = '{"t4_c6",    1'b0,1'b0,32'h0,    32'h0,         1'b1,1'b0,3'b010,32'h4010,     32'h0,         1'b1,32'h204,    3'b010,1'b1,1'b1,1'b0,32'h4010,   3'b010,32'h0,         3'b010,32'h400C_C0DE};
    vecs[16] = '{"t4_r1",    1'b0,1'b0,32'h0,    32'h0,         1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b0,32'h0,      3'b000,1'b0,1'b0,1'b0,32'h0,      3'b000,32'h0,         3'b001,32'h0200_C0DE};
    vecs[17] = '{"t4_r2",    1'b0,1'b0,32'h0,    32'h0,         1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b0,32'h0,      3'b000,1'b0,1'b0,1'b0,32'h0,      3'b000,32'h0,         3'b010,32'h4010_C0DE};
    vecs[18] = '{"t5_all",   1'b1,1'b0,32'h500,  32'h0,         1'b1,1'b0,3'b010,32'h600,      32'h0,         1'b1,32'h700,    3'b100,1'b1,1'b1,1'b0,32'h500,    3'b010,32'h0,         3'b000,32'h0};
    vecs[19] = '{"t5_dm",    1'b0,1'b0,32'h0,    32'h0,         1'b1,1'b0,3'b010,32'h600,      32'h0,         1'b1,32'h700,    3'b010,1'b1,1'b1,1'b0,32'h600,    3'b010,32'h0,         3'b000,32'h0};
    vecs[20] = '{"t5_if",    1'b0,1'b0,32'h0,    32'h0,         1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b1,32'h700,    3'b001,1'b0,1'b1,1'b0,32'h700,    3'b010,32'h0,         3'b100,32'h0500_C0DE};
    vecs[21] = '{"t5_rdm",   1'b0,1'b0,32'h0,    32'h0,         1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b0,32'h0,      3'b000,1'b0,1'b0,1'b0,32'h0,      3'b000,32'h0,         3'b010,32'h0600_C0DE};
    vecs[22] = '{"t5_rif",   1'b0,1'b0,32'h0,    32'h0,         1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b0,32'h0,      3'b000,1'b0,1'b0,1'b0,32'h0,      3'b000,32'h0,         3'b001,32'h0700_C0DE};
    vecs[23] = '{"dbg_wr",   1'b1,1'b1,32'h800,  32'h1234_5678, 1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b1,32'h704,    3'b100,1'b1,1'b0,1'b1,32'h800,    3'b010,32'h1234_5678, 3'b000,32'h0};
    vecs[24] = '{"dbg_wr_if",1'b0,1'b0,32'h0,    32'h0,         1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b1,32'h704,    3'b001,1'b0,1'b1,1'b0,32'h704,    3'b010,32'h0,         3'b000,32'h0};
    vecs[25] = '{"dbg_norv", 1'b0,1'b0,32'h0,    32'h0,         1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b0,32'h0,      3'b000,1'b0,1'b0,1'b0,32'h0,      3'b000,32'h0,         3'b000,32'h0};
    vecs[26] = '{"dbg_rif",  1'b0,1'b0,32'h0,    32'h0,         1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b0,32'h0,      3'b000,1'b0,1'b0,1'b0,32'h0,      3'b000,32'h0,         3'b001,32'h0704_C0DE};

    // Reset held with every requester active: all outputs must be zero.
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'h10, 32'h55, 1'b1, 1'b1, 3'b001, 32'h20, 32'h66, 1'b1, 32'h30);
    #2;
    check("reset_outputs", all_outputs(), 256'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_idle();

    for (int i = 0; i < 27; i++) begin
      @(posedge clk);
      #1;
      run_vec(vecs[i]);
    end

    // Reset mid-operation: build up starvation, then reset while a read is in flight.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h900 + 32'(4 * k), 32'h0, 1'b1, 32'hA00);
      #4;
      check($sformatf("pre_rst_gnt%0d", k),
            256'({bus.dbg_gnt_o, bus.dmem_gnt_o, bus.if_gnt_o}), 256'(3'b010));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'h10, 32'h55, 1'b1, 1'b0, 3'b010, 32'h90C, 32'h0, 1'b1, 32'hA00);
    #4;
    check("mid_rst_out0", all_outputs(), 256'h0);
    @(posedge clk);
    #4;
    check("mid_rst_out1", all_outputs(), 256'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h910 + 32'(4 * k), 32'h0, 1'b1, 32'hA00);
      #4;
      check($sformatf("post_rst_gnt%0d", k),
            256'({bus.dbg_gnt_o, bus.dmem_gnt_o, bus.if_gnt_o, bus.hold_flag_o}), 256'(4'b0101));
      if (k < 2)
        check($sformatf("post_rst_norv%0d", k),
              256'({bus.dbg_rvalid_o, bus.dmem_rvalid_o, bus.if_rvalid_o,
                    bus.dbg_rdata_o, bus.dmem_rdata_o, bus.if_rdata_o}), 256'h0);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h920, 32'h0, 1'b1, 32'hA00);
    #4;
    check("post_rst_starve_if",
          256'({bus.dbg_gnt_o, bus.dmem_gnt_o, bus.if_gnt_o, bus.hold_flag_o}), 256'(4'b0010));
    @(posedge clk);
    #1;
    drive_idle();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
